// File: rtl/hwpe_ctrl_package.sv
`default_nettype none
// ============================================================================
// hwpe_ctrl_package : shared constants and helpers for the HWPE control path
// Revision: 1.0
// ============================================================================
package hwpe_ctrl_package;

    localparam int unsigned DEFAULT_ID_WIDTH = 4;
    // Widest ID vector the one-hot checker accepts; narrower IDs are zero-extended.
    localparam int unsigned MAX_ID_WIDTH     = 32;

    function automatic logic onehot_is_valid(input logic [MAX_ID_WIDTH-1:0] id);
        return (id != '0) && ((id & (id - 1'b1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_ctrl_rr_prio.sv
`default_nettype none
// ============================================================================
// hwpe_ctrl_rr_prio : round-robin priority encoder starting at a pointer
// Revision: 1.0
// ============================================================================
module hwpe_ctrl_rr_prio #(
    parameter  int unsigned N         = 4,
    localparam int unsigned IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] winner,
    output logic [N-1:0]         winner_oh,
    output logic                 any
);

    logic                 hit_hi;
    logic [IDX_WIDTH-1:0] win_hi;
    logic [IDX_WIDTH-1:0] win_lo;

    assign any = |req;

    // Scanning downwards leaves the lowest matching index in each candidate:
    // win_hi is the first request at or above ptr, win_lo the wrap-around one.
    always_comb begin
        hit_hi = 1'b0;
        win_hi = '0;
        win_lo = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_lo = IDX_WIDTH'(k);
                if (k >= int'(ptr)) begin
                    hit_hi = 1'b1;
                    win_hi = IDX_WIDTH'(k);
                end
            end
        end
        winner = hit_hi ? win_hi : win_lo;
    end

    always_comb begin
        winner_oh = '0;
        for (int k = 0; k < N; k++) begin
            winner_oh[k] = any && (winner == IDX_WIDTH'(k));
        end
    end

endmodule
`default_nettype wire

// File: rtl/hwpe_ctrl_periph_arbiter.sv
`default_nettype none
// ============================================================================
// hwpe_ctrl_periph_arbiter : N-master round-robin arbiter into the HWPE
// control slave with one-hot source ID and response routing.
// Revision: 1.0
// ============================================================================
module hwpe_ctrl_periph_arbiter
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CORES    = DEFAULT_ID_WIDTH,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          REG_RSP    = 1'b0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,

    input  logic [N_CORES-1:0]                    mst_req_i,
    output logic [N_CORES-1:0]                    mst_gnt_o,
    input  logic [N_CORES-1:0][ADDR_WIDTH-1:0]    mst_add_i,
    input  logic [N_CORES-1:0]                    mst_wen_i,
    input  logic [N_CORES-1:0][DATA_WIDTH/8-1:0]  mst_be_i,
    input  logic [N_CORES-1:0][DATA_WIDTH-1:0]    mst_data_i,
    output logic [N_CORES-1:0]                    mst_r_valid_o,
    output logic [N_CORES-1:0][DATA_WIDTH-1:0]    mst_r_data_o,

    output logic                                  slv_req_o,
    input  logic                                  slv_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 slv_add_o,
    output logic                                  slv_wen_o,
    output logic [DATA_WIDTH/8-1:0]               slv_be_o,
    output logic [DATA_WIDTH-1:0]                 slv_data_o,
    output logic [N_CORES-1:0]                    slv_id_o,
    input  logic                                  slv_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                 slv_r_data_i,
    input  logic [N_CORES-1:0]                    slv_r_id_i,

    output logic                                  err_o
);

    localparam int unsigned PTR_WIDTH = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [PTR_WIDTH-1:0] ptr;
    logic [PTR_WIDTH-1:0] ptr_next;
    logic [PTR_WIDTH-1:0] winner;
    logic [N_CORES-1:0]   winner_oh;
    logic                 any_req;
    logic                 handshake;
    logic                 soft_rst;
    logic                 err;
    logic [N_CORES-1:0]   rsp_valid_in;
    logic [N_CORES-1:0]   rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign soft_rst = rst_i | clear_i;

    hwpe_ctrl_rr_prio #(
        .N (N_CORES)
    ) i_rr_prio (
        .req       (mst_req_i),
        .ptr       (ptr),
        .winner    (winner),
        .winner_oh (winner_oh),
        .any       (any_req)
    );

    // Only the hard reset blanks the request side; clear_i lets traffic through.
    assign slv_req_o  = any_req & ~rst_i;
    assign slv_id_o   = rst_i ? '0 : winner_oh;
    assign mst_gnt_o  = rst_i ? '0 : (winner_oh & {N_CORES{slv_gnt_i}});
    assign slv_add_o  = mst_add_i[winner];
    assign slv_wen_o  = mst_wen_i[winner];
    assign slv_be_o   = mst_be_i[winner];
    assign slv_data_o = mst_data_i[winner];

    assign handshake = slv_req_o & slv_gnt_i;
    assign ptr_next  = (winner == PTR_WIDTH'(N_CORES - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= ptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            err <= 1'b0;
        end else if (slv_r_valid_i && !onehot_is_valid(MAX_ID_WIDTH'(slv_r_id_i))) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;

    // A malformed ID is still forwarded to every core whose bit it carries.
    assign rsp_valid_in = {N_CORES{slv_r_valid_i}} & slv_r_id_i;

    if (REG_RSP) begin : g_reg_rsp
        always_ff @(posedge clk_i) begin
            if (soft_rst) begin
                rsp_valid <= '0;
                rsp_data  <= '0;
            end else begin
                rsp_valid <= rsp_valid_in;
                rsp_data  <= slv_r_data_i;
            end
        end
    end else begin : g_comb_rsp
        assign rsp_valid = rsp_valid_in;
        assign rsp_data  = slv_r_data_i;
    end

    assign mst_r_valid_o = rsp_valid;

    for (genvar k = 0; k < N_CORES; k++) begin : g_rdata_lane
        assign mst_r_data_o[k] = rsp_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
`default_nettype none
// ============================================================================
// tb_hwpe_ctrl_periph_arbiter : scoreboard bench driving a REG_RSP=0 and a
// REG_RSP=1 instance with the same directed stimulus.
// Revision: 1.0
// ============================================================================
module tb_hwpe_ctrl_periph_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [N-1:0]    id;
        logic [AW-1:0]   add;
        logic            wen;
        logic [DW/8-1:0] be;
        logic [DW-1:0]   data;
        logic [N-1:0]    gnt;
    } req_exp_t;

    typedef struct {
        logic [N-1:0]  valid;
        logic [DW-1:0] data;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst, clear;
    logic [N-1:0]            mst_req;
    logic [N-1:0][AW-1:0]    mst_add;
    logic [N-1:0]            mst_wen;
    logic [N-1:0][DW/8-1:0]  mst_be;
    logic [N-1:0][DW-1:0]    mst_data;
    logic                    slv_gnt;
    logic                    slv_r_valid;
    logic [DW-1:0]           slv_r_data;
    logic [N-1:0]            slv_r_id;

    logic [N-1:0]            mst_gnt     [2];
    logic [N-1:0]            mst_r_valid [2];
    logic [N-1:0][DW-1:0]    mst_r_data  [2];
    logic                    slv_req     [2];
    logic [AW-1:0]           slv_add     [2];
    logic                    slv_wen     [2];
    logic [DW/8-1:0]         slv_be      [2];
    logic [DW-1:0]           slv_data    [2];
    logic [N-1:0]            slv_id      [2];
    logic                    err         [2];

    req_exp_t req_q  [$];
    rsp_exp_t rsp_q0 [$];
    rsp_exp_t rsp_q1 [$];
    req_exp_t re;
    rsp_exp_t rr;

    int nchk = 0;
    int nerr = 0;
    int cnt [N];
    logic fair = 1'b0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        hwpe_ctrl_periph_arbiter #(
            .N_CORES    (N),
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .REG_RSP    (d[0])
        ) dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .clear_i       (clear),
            .mst_req_i     (mst_req),
            .mst_gnt_o     (mst_gnt[d]),
            .mst_add_i     (mst_add),
            .mst_wen_i     (mst_wen),
            .mst_be_i      (mst_be),
            .mst_data_i    (mst_data),
            .mst_r_valid_o (mst_r_valid[d]),
            .mst_r_data_o  (mst_r_data[d]),
            .slv_req_o     (slv_req[d]),
            .slv_gnt_i     (slv_gnt),
            .slv_add_o     (slv_add[d]),
            .slv_wen_o     (slv_wen[d]),
            .slv_be_o      (slv_be[d]),
            .slv_data_o    (slv_data[d]),
            .slv_id_o      (slv_id[d]),
            .slv_r_valid_i (slv_r_valid),
            .slv_r_data_i  (slv_r_data),
            .slv_r_id_i    (slv_r_id),
            .err_o         (err[d])
        );
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expw(input int w, input logic g);
        req_exp_t e;
        e.id   = 4'b0001 << w;
        e.add  = mst_add[w];
        e.wen  = mst_wen[w];
        e.be   = mst_be[w];
        e.data = mst_data[w];
        e.gnt  = g ? e.id : 4'b0000;
        req_q.push_back(e);
    endtask

    task automatic exprsp(input logic [N-1:0] v, input logic [DW-1:0] dat, input logic both);
        rsp_exp_t e;
        e.valid = v;
        e.data  = dat;
        rsp_q0.push_back(e);
        if (both) rsp_q1.push_back(e);
    endtask

    // Request-side and response-side monitor
    always @(negedge clk) begin
        if (slv_req[0] || slv_req[1]) begin
            if (req_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL req_unexpected: got id %b / %b expected no request", slv_id[0], slv_id[1]);
            end else begin
                re = req_q.pop_front();
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("req_dut%0d", d),
                          {slv_req[d], slv_id[d], slv_add[d], slv_wen[d], slv_be[d], slv_data[d], mst_gnt[d]},
                          {1'b1, re.id, re.add, re.wen, re.be, re.data, re.gnt});
                end
            end
        end
        if (fair) begin
            for (int k = 0; k < N; k++) if (mst_gnt[0][k]) cnt[k]++;
        end
        if (|mst_r_valid[0]) begin
            if (rsp_q0.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL rsp_unexpected_dut0: got valid %b expected none", mst_r_valid[0]);
            end else begin
                rr = rsp_q0.pop_front();
                check("rsp_dut0", {mst_r_valid[0], mst_r_data[0]}, {rr.valid, {N{rr.data}}});
            end
        end
        if (|mst_r_valid[1]) begin
            if (rsp_q1.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL rsp_unexpected_dut1: got valid %b expected none", mst_r_valid[1]);
            end else begin
                rr = rsp_q1.pop_front();
                check("rsp_dut1", {mst_r_valid[1], mst_r_data[1]}, {rr.valid, {N{rr.data}}});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) cnt[k] = 0;
        mst_add     = {32'h0000_010C, 32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
        mst_wen     = 4'b0101;
        mst_be      = {4'h8, 4'h4, 4'h2, 4'h1};
        mst_data    = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        rst         = 1'b1;
        clear       = 1'b0;
        mst_req     = 4'b1111;
        slv_gnt     = 1'b1;
        slv_r_valid = 1'b0;
        slv_r_id    = '0;
        slv_r_data  = '0;

        // Reset blanks every request-side output even with all masters requesting
        repeat (2) begin
            cyc();
            #2;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("rst_req_dut%0d", d), {slv_req[d], mst_gnt[d], slv_id[d], err[d]}, '0);
            end
            check("rst_rsp_dut1", {mst_r_valid[1], mst_r_data[1]}, '0);
        end

        // Fairness: strict 0,1,2,3 rotation starting at core 0
        cyc();
        rst  = 1'b0;
        fair = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i != 0) cyc();
            expw(i % 4, 1'b1);
        end
        cyc();
        fair    = 1'b0;
        mst_req = 4'b0000;

        // Stall: winner held at 1 while gnt low, then 1, 3, wrap to 1
        cyc(); mst_req = 4'b1010; slv_gnt = 1'b0; expw(1, 1'b0);
        cyc(); expw(1, 1'b0);
        cyc(); expw(1, 1'b0);
        cyc(); slv_gnt = 1'b1; expw(1, 1'b1);
        cyc(); expw(3, 1'b1);
        cyc(); expw(1, 1'b1);

        // Single requester wins regardless of ptr
        cyc(); mst_req = 4'b0001; expw(0, 1'b1);
        cyc(); expw(0, 1'b1);
        cyc(); expw(0, 1'b1);
        cyc(); mst_req = 4'b1000; expw(3, 1'b1);
        cyc(); expw(3, 1'b1);

        // Response routing and latency for both response modes
        cyc(); mst_req = 4'b0100; expw(2, 1'b1);
        cyc(); mst_req = 4'b0000; slv_r_valid = 1'b1; slv_r_id = 4'b0100; slv_r_data = 32'hDEAD_BEEF;
        exprsp(4'b0100, 32'hDEAD_BEEF, 1'b1);
        #2;
        check("rsp_lat_dut0", mst_r_valid[0], 4'b0100);
        check("rsp_lat_dut1", mst_r_valid[1], 4'b0000);
        cyc(); slv_r_id = 4'b0001; slv_r_data = 32'h1234_5678;
        exprsp(4'b0001, 32'h1234_5678, 1'b1);
        #2;
        check("rsp_reg_dut1", mst_r_valid[1], 4'b0100);
        cyc(); slv_r_valid = 1'b0; slv_r_id = '0; slv_r_data = '0;
        #2;
        check("rsp_idle_dut0", mst_r_valid[0], 4'b0000);
        check("rsp_reg2_dut1", mst_r_valid[1], 4'b0001);
        check("err_clean", {err[0], err[1]}, 2'b00);

        // Malformed ID: forwarded masked, err sticky until clear
        cyc(); mst_req = 4'b0010; slv_r_valid = 1'b1; slv_r_id = 4'b0110; slv_r_data = 32'hCAFE_0000;
        expw(1, 1'b1);
        exprsp(4'b0110, 32'hCAFE_0000, 1'b1);
        #2;
        check("err_same_cycle", {err[0], err[1]}, 2'b00);
        cyc(); mst_req = 4'b0000; slv_r_valid = 1'b0; slv_r_id = '0; slv_r_data = '0;
        #2;
        check("err_set", {err[0], err[1]}, 2'b11);
        cyc(); #2;
        check("err_sticky", {err[0], err[1]}, 2'b11);
        cyc(); clear = 1'b1;
        #2;
        check("err_before_clear", {err[0], err[1]}, 2'b11);
        cyc(); clear = 1'b0; mst_req = 4'b1111; expw(0, 1'b1);
        #2;
        check("err_cleared", {err[0], err[1]}, 2'b00);

        // Zero ID is also an error and routes nowhere
        cyc(); mst_req = 4'b0000; slv_r_valid = 1'b1; slv_r_id = 4'b0000; slv_r_data = 32'h0000_0BAD;
        #2;
        check("rsp_zero_id", mst_r_valid[0], 4'b0000);
        cyc(); slv_r_valid = 1'b0; slv_r_data = '0;
        #2;
        check("err_zero_id", {err[0], err[1]}, 2'b11);

        // Clear racing a handshake: clear wins, core 0 wins next
        cyc(); mst_req = 4'b0010; clear = 1'b1; expw(1, 1'b1);
        cyc(); clear = 1'b0; mst_req = 4'b1111; expw(0, 1'b1);
        #2;
        check("err_race_clear", {err[0], err[1]}, 2'b00);
        cyc(); mst_req = 4'b1000; clear = 1'b1; expw(3, 1'b1);
        cyc(); clear = 1'b0; mst_req = 4'b1111; expw(0, 1'b1);

        // Reset mid-transfer drops the registered response
        cyc(); mst_req = 4'b0010; expw(1, 1'b1);
        cyc(); mst_req = 4'b0000; rst = 1'b1; slv_r_valid = 1'b1; slv_r_id = 4'b0010; slv_r_data = 32'h55AA_55AA;
        exprsp(4'b0010, 32'h55AA_55AA, 1'b0);
        cyc(); rst = 1'b0; slv_r_valid = 1'b0; slv_r_id = '0; slv_r_data = '0;
        #2;
        check("rst_drop_dut1", {mst_r_valid[1], mst_r_data[1]}, '0);
        cyc(); mst_req = 4'b1111; expw(0, 1'b1);
        cyc(); mst_req = 4'b0000;
        repeat (3) cyc();

        check("req_q_drained", 160'(req_q.size()), 160'(0));
        check("rsp_q0_drained", 160'(rsp_q0.size()), 160'(0));
        check("rsp_q1_drained", 160'(rsp_q1.size()), 160'(0));
        for (int k = 0; k < N; k++) begin
            check($sformatf("fair_core%0d", k), 160'(cnt[k]), 160'(100));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
